// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready_o depends only on registered state plus ctrl hold/flush, never on out_ready_i.
module pipe_stage_skid #(
  parameter int unsigned    DW      = 32,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          hold_flag_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    count_o
);

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] main_data_q,  main_data_d;
  logic [DW-1:0] skid_data_q,  skid_data_d;
  logic [1:0]    count_q,      count_d;
  logic          push, pop;

  assign in_ready_o  = !skid_valid_q & !hold_flag_i & !flush_i;
  assign out_valid_o = main_valid_q & !hold_flag_i & !flush_i;
  assign out_data_o  = main_valid_q ? main_data_q : RST_VAL;
  assign count_o     = count_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    // NOTE: every _d signal takes its current value first, so no path leaves it unassigned (no latch).
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = RST_VAL;
      skid_data_d  = RST_VAL;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (push) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data_i;
          end
        end
        2'b10: begin
          if (push && pop) begin
            main_data_d = in_data_i;
          end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
          end else if (pop) begin
            main_valid_d = 1'b0;
            main_data_d  = RST_VAL;
          end
        end
        2'b11: begin
          // Skid is always younger than main, so it moves up on a pop.
          if (pop) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = RST_VAL;
          end
        end
        default: begin
          // Skid-only is unreachable; promote it so the stage self-heals.
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
          skid_data_d  = RST_VAL;
        end
      endcase
    end

    count_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: data registers are reset as well, so the payload is RST_VAL straight out of reset.
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= RST_VAL;
      skid_data_q  <= RST_VAL;
      count_q      <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      count_q      <= count_d;
    end
  end

endmodule
